// File: rtl/instr_fetch_pkg.sv
// Shared fetch/control types: fetch FSM states, control states, opcodes.
// Fetch width constant used by the prefetch address sequencer.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DROP,
        HALT
    } FetchState;

    typedef enum logic [1:0] {
        C_RESET,
        C_DECODE,
        C_EXEC,
        C_WB
    } ControlState;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } OpCode;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch FIFO of {pc, word} entries with synchronous flush.
// Storage is reset to zero so the head reads 0 out of reset.
module fetch_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [63:0]              wdata,
    output logic [63:0]              rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: req/ack memory port, prefetch FIFO, redirects.
// Optional misaligned-redirect halt enabled by FETCH_ALIGN_CHECK_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    FetchState     state;
    logic [31:0]   req_pc;
    logic [31:0]   pending_pc;
    logic [31:0]   rpc;
    logic [CW-1:0] count;
    logic [63:0]   head;
    logic          misaligned;
    logic          halt_next;
    logic          ack;
    logic          push;
    logic          pop;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;

    assign rpc        = redirect_pc;
    assign misaligned = |redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              fault_q <= 1'b0;
        else if (redirect_valid) fault_q <= misaligned;
    end

    assign fetch_fault = fault_q;
`else
    logic unused_low;

    assign rpc         = {redirect_pc[31:2], 2'b00};
    assign misaligned  = 1'b0;
    assign unused_low  = ^redirect_pc[1:0];
    assign fetch_fault = 1'b0;
`endif

    // The newest redirect decides whether a drained DROP ends in HALT.
    assign halt_next = redirect_valid ? misaligned : fetch_fault;

    assign mem_req  = ((state == FETCH) && (count < CW'(DEPTH)))
                   || (state == DROP);
    assign mem_addr = req_pc;
    assign ack      = mem_req && mem_ack;

    assign instr_valid = (count != '0) && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign push        = (state == FETCH) && ack && !redirect_valid;
    assign instr       = head[31:0];
    assign instr_pc    = head[63:32];

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({req_pc, mem_rdata}),
        .rdata (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_pc     <= RESET_PC;
            pending_pc <= RESET_PC;
        end else begin
            unique case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (redirect_valid) begin
                        if (mem_req && !mem_ack) begin
                            state      <= DROP;
                            pending_pc <= rpc;
                        end else if (misaligned) begin
                            state <= HALT;
                        end else begin
                            req_pc <= rpc;
                        end
                    end else if (ack) begin
                        req_pc <= req_pc + INSTR_BYTES;
                    end
                end
                DROP: begin
                    if (redirect_valid) pending_pc <= rpc;
                    if (mem_ack) begin
                        if (halt_next) begin
                            state <= HALT;
                        end else begin
                            state  <= FETCH;
                            req_pc <= redirect_valid ? rpc : pending_pc;
                        end
                    end
                end
                HALT: begin
                    if (redirect_valid && !misaligned) begin
                        state  <= FETCH;
                        req_pc <= rpc;
                    end
                end
            endcase
        end
    end

endmodule
